// File: rtl/triplet_feeder.sv
// triplet_feeder: buffers {a,b,c} operand triplets in a small FIFO and serializes
// each one as three back-to-back beats, followed by a forced idle gap.
module triplet_feeder #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [31:0]                in_c,
    output logic                       valido,
    output logic [31:0]                data_out,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [15:0]                sent_count,
    output logic                       busy
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [2:0] GAP_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    typedef enum logic [2:0] {IDLE, SA, SB, SC, GP} state_t;

    state_t        state_q, state_d;
    logic [95:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [63:0]   hold_q, hold_d;
    logic [31:0]   data_q, data_d;
    logic          valido_q, valido_d;
    logic          busy_q, busy_d;
    logic [15:0]   sent_count_q, sent_count_d;
    logic [2:0]    gap_q, gap_d;
    logic          push, pop, launch;
    logic [95:0]   head;

    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        hold_d       = hold_q;
        valido_d     = 1'b0;
        sent_count_d = sent_count_q;
        gap_d        = gap_q;
        launch       = 1'b0;
        case (state_q)
            IDLE: launch = (level_q != '0);
            SA: begin
                data_d   = hold_q[63:32];
                valido_d = 1'b1;
                state_d  = SB;
            end
            SB: begin
                data_d   = hold_q[31:0];
                valido_d = 1'b1;
                state_d  = SC;
            end
            SC: begin
                sent_count_d = sent_count_q + 16'd1;
                if (GAP == 0) begin
                    state_d = IDLE;
                    launch  = (level_q != '0);
                end else begin
                    gap_d   = GAP_LOAD;
                    state_d = GP;
                end
            end
            GP: begin
                // Last gap cycle doubles as the IDLE decision so the period stays 3+GAP.
                if (gap_q == '0) begin
                    state_d = IDLE;
                    launch  = (level_q != '0);
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            data_d   = head[95:64];
            hold_d   = head[63:0];
            valido_d = 1'b1;
            state_d  = SA;
        end
        busy_d = (state_d != IDLE);
    end

    assign pop = launch;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            hold_q       <= '0;
            data_q       <= '0;
            valido_q     <= 1'b0;
            busy_q       <= 1'b0;
            sent_count_q <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            data_q       <= data_d;
            valido_q     <= valido_d;
            busy_q       <= busy_d;
            sent_count_q <= sent_count_d;
            gap_q        <= gap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b, in_c};
        end
    end

    assign valido     = valido_q;
    assign data_out   = data_q;
    assign level      = level_q;
    assign sent_count = sent_count_q;
    assign busy       = busy_q;
endmodule
